// File: rtl/piped_adder_arb.sv
// rtl/piped_adder_arb.sv - round-robin scheduler for one shared pipelined adder tree, tagged results
// Optional build macro: PIPED_ADDER_ARB_PRIO_EN (requester 0 gets strict priority)
module piped_adder_arb #(
    parameter int N_req       = 4,
    parameter int N_args      = 8,
    parameter int arg_width   = 4,
    parameter int tree_height = $clog2(N_args),
    parameter int sum_width   = arg_width + tree_height,
    parameter int id_width    = $clog2(N_req)
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic [N_req-1:0]                  req,
    input  logic [N_req*N_args*arg_width-1:0] args_bus,
    output logic [N_req-1:0]                  ack,
    output logic [N_args*arg_width-1:0]       add_args,
    output logic                              add_we,
    input  logic [sum_width-1:0]              add_sum,
    input  logic                              add_valid,
    output logic [sum_width-1:0]              res_data,
    output logic [id_width-1:0]               res_id,
    output logic                              res_valid,
    output logic                              err
);

    localparam int slice_w = N_args * arg_width;
    localparam int flush_w = $clog2(tree_height + 1);

    logic [id_width-1:0] ptr;
    logic                grant;
    logic [id_width-1:0] grant_id;
    logic                ptr_hold;
    int                  scan_idx;

    // Stage 0 travels alongside add_we; stages 1..tree_height mirror the adder,
    // so the last stage lines up with add_valid.
    logic [tree_height:0] tag_valid;
    logic [id_width-1:0]  tag_id [tree_height+1];

    // Adder has no reset: stale sums can surface for tree_height clks after rst.
    logic [flush_w-1:0]   flush_cnt;

    // Pick the first requester at or after ptr, wrapping; nothing granted in reset.
    always_comb begin
        grant    = 1'b0;
        grant_id = '0;
        ptr_hold = 1'b0;
        scan_idx = 0;
        for (int i = 0; i < N_req; i++) begin
            scan_idx = (int'(ptr) + i) % N_req;
            if (!grant && req[scan_idx]) begin
                grant    = 1'b1;
                grant_id = id_width'(scan_idx);
            end
        end
`ifdef PIPED_ADDER_ARB_PRIO_EN
        if (req[0]) begin
            grant    = 1'b1;
            grant_id = '0;
            ptr_hold = 1'b1;
        end
`endif
        if (rst) begin
            grant = 1'b0;
        end
    end

    assign ack = grant ? (N_req'(1) << grant_id) : '0;

    // Issue granted vector to the adder, track its ID, and retire results.
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr       <= '0;
            add_we    <= 1'b0;
            add_args  <= '0;
            tag_valid <= '0;
            for (int i = 0; i <= tree_height; i++) begin
                tag_id[i] <= '0;
            end
            res_valid <= 1'b0;
            res_data  <= '0;
            res_id    <= '0;
            err       <= 1'b0;
            flush_cnt <= flush_w'(tree_height);
        end else begin
            add_we <= grant;
            if (grant) begin
                add_args <= args_bus[int'(grant_id)*slice_w +: slice_w];
                if (!ptr_hold) begin
                    ptr <= id_width'((int'(grant_id) + 1) % N_req);
                end
            end

            tag_valid <= {tag_valid[tree_height-1:0], grant};
            tag_id[0] <= grant_id;
            for (int i = 1; i <= tree_height; i++) begin
                tag_id[i] <= tag_id[i-1];
            end

            res_valid <= 1'b0;
            if (flush_cnt != '0) begin
                flush_cnt <= flush_cnt - 1'b1;
            end else begin
                if (add_valid) begin
                    res_valid <= 1'b1;
                    res_data  <= add_sum;
                    res_id    <= tag_id[tree_height];
                end
                if (add_valid != tag_valid[tree_height]) begin
                    err <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_piped_adder_arb.sv
// tb/tb_piped_adder_arb.sv - directed self-checking bench for piped_adder_arb
module tb_piped_adder_arb;

    localparam int N_req     = 4;
    localparam int N_args    = 8;
    localparam int arg_width = 4;
    localparam int th        = 3;
    localparam int sum_width = 7;
    localparam int id_width  = 2;
    localparam int slice_w   = N_args * arg_width;

    logic                         clk;
    logic                         rst;
    logic [N_req-1:0]             req;
    logic [N_req*slice_w-1:0]     args_bus;
    logic [N_req-1:0]             ack;
    logic [slice_w-1:0]           add_args;
    logic                         add_we;
    logic [sum_width-1:0]         add_sum;
    logic                         add_valid;
    logic [sum_width-1:0]         res_data;
    logic [id_width-1:0]          res_id;
    logic                         res_valid;
    logic                         err;

    piped_adder_arb dut (
        .clk(clk), .rst(rst), .req(req), .args_bus(args_bus), .ack(ack),
        .add_args(add_args), .add_we(add_we), .add_sum(add_sum), .add_valid(add_valid),
        .res_data(res_data), .res_id(res_id), .res_valid(res_valid), .err(err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Adder model: no reset, latency th clks, valid delayed with the data.
    logic [sum_width-1:0] pipe_sum [th];
    logic [th-1:0]        pipe_v;
    logic                 force_v;

    function automatic logic [sum_width-1:0] sum_slice(input logic [slice_w-1:0] s);
        logic [sum_width-1:0] acc;
        acc = '0;
        for (int i = 0; i < N_args; i++) acc = acc + sum_width'(s[i*arg_width +: arg_width]);
        return acc;
    endfunction

    always @(posedge clk) begin
        pipe_sum[0] <= sum_slice(add_args);
        pipe_v[0]   <= add_we;
        for (int i = 1; i < th; i++) begin
            pipe_sum[i] <= pipe_sum[i-1];
            pipe_v[i]   <= pipe_v[i-1];
        end
    end

    assign add_sum   = pipe_sum[th-1];
    assign add_valid = pipe_v[th-1] | force_v;

    // Result log: id*256+data plus the cycle it was seen.
    int res_q[$];
    int res_cyc[$];
    int cyc;

    always @(negedge clk) begin
        cyc <= cyc + 1;
        if (res_valid) begin
            res_q.push_back(int'(res_id) * 256 + int'(res_data));
            res_cyc.push_back(cyc);
        end
    end

    int n_checks;
    int n_fail;

    task automatic check_eq(input string tag, input int got, input int exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic clear_log();
        res_q.delete();
        res_cyc.delete();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        req = '0;
        repeat (3) tick();
        rst = 1'b0;
        repeat (th + 1) tick();
        clear_log();
    endtask

    function automatic logic [slice_w-1:0] fill(input logic [3:0] v);
        return {N_args{v}};
    endfunction

    int lat;
    int got_lat;

    initial begin
        n_checks = 0;
        n_fail   = 0;
        cyc      = 0;
        force_v  = 1'b0;
        pipe_v   = '0;
        rst      = 1'b1;
        req      = '1;
        args_bus = {fill(4'd4), fill(4'd3), fill(4'd2), fill(4'd1)};

        // Reset state, with all requests raised
        repeat (2) tick();
        #1;
        check_eq("rst_ack", ack, 0);
        check_eq("rst_add_we", add_we, 0);
        check_eq("rst_add_args", int'(add_args), 0);
        check_eq("rst_res_valid", res_valid, 0);
        check_eq("rst_res_data", res_data, 0);
        check_eq("rst_res_id", res_id, 0);
        check_eq("rst_err", err, 0);
        req = '0;
        rst = 1'b0;
        repeat (th + 1) tick();
        clear_log();

        // 1: single request from 0, latency ack+5
        req = 4'b0001;
        #1 check_eq("t1_ack", ack, 1);
        got_lat = 0;
        for (lat = 1; lat <= 10; lat++) begin
            tick();
            if (lat == 1) begin
                check_eq("t1_add_we", add_we, 1);
                check_eq("t1_add_args", int'(add_args), 32'h1111_1111);
                req = '0;
            end
            if (res_valid && got_lat == 0) got_lat = lat;
        end
        check_eq("t1_latency", got_lat, 5);
        check_eq("t1_count", res_q.size(), 1);
        if (res_q.size() >= 1) check_eq("t1_result", res_q[0], 0 * 256 + 8);

        // 2: all four requesting for 8 clks from ptr=0
        do_reset();
        req = 4'b1111;
        for (int i = 0; i < 8; i++) begin
            #1 check_eq($sformatf("t2_ack%0d", i), ack, 1 << (i % 4));
            tick();
        end
        req = '0;
        repeat (12) tick();
        check_eq("t2_count", res_q.size(), 8);
        for (int i = 0; i < 8 && i < res_q.size(); i++)
            check_eq($sformatf("t2_res%0d", i), res_q[i], (i % 4) * 256 + 8 * ((i % 4) + 1));

        // 3: lone requester 2 re-granted every clk
        clear_log();
        req = 4'b0100;
        for (int i = 0; i < 4; i++) begin
            #1 check_eq($sformatf("t3_ack%0d", i), ack, 4);
            tick();
        end
        req = '0;
        repeat (10) tick();
        check_eq("t3_count", res_q.size(), 4);
        for (int i = 0; i < 4 && i < res_q.size(); i++)
            check_eq($sformatf("t3_res%0d", i), res_q[i], 2 * 256 + 24);
        for (int i = 1; i < 4 && i < res_cyc.size(); i++)
            check_eq($sformatf("t3_back2back%0d", i), res_cyc[i] - res_cyc[i-1], 1);

        // 4: reset while a sum is still inside the adder
        clear_log();
        req = 4'b0001;
        #1 check_eq("t4_ack", ack, 1);
        tick();
        req = '0;
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        for (int i = 0; i < 6; i++) begin
            tick();
            check_eq($sformatf("t4_flush_err%0d", i), err, 0);
        end
        check_eq("t4_no_stale", res_q.size(), 0);
        req = 4'b0010;
        #1 check_eq("t4_ack_after", ack, 2);
        tick();
        req = '0;
        repeat (8) tick();
        check_eq("t4_count_after", res_q.size(), 1);
        if (res_q.size() >= 1) check_eq("t4_res_after", res_q[0], 1 * 256 + 16);

        // 5: spurious add_valid with empty tag pipe -> sticky err
        force_v = 1'b1;
        tick();
        force_v = 1'b0;
        check_eq("t5_err", err, 1);
        check_eq("t5_res_valid_follows", res_valid, 1);
        repeat (3) tick();
        check_eq("t5_err_sticky", err, 1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_eq("t5_err_cleared", err, 0);

        // 6: requester 0 with others active
        do_reset();
`ifdef PIPED_ADDER_ARB_PRIO_EN
        req = 4'b0111;
        for (int i = 0; i < 4; i++) begin
            #1 check_eq($sformatf("t6_prio_ack%0d", i), ack, 1);
            tick();
        end
        req = 4'b0110;
        for (int i = 0; i < 4; i++) begin
            #1 check_eq($sformatf("t6_rr_ack%0d", i), ack, (i % 2 == 0) ? 2 : 4);
            tick();
        end
`else
        req = 4'b0111;
        for (int i = 0; i < 6; i++) begin
            #1 check_eq($sformatf("t6_rr_ack%0d", i), ack, 1 << (i % 3));
            tick();
        end
`endif
        req = '0;
        repeat (8) tick();
        check_eq("t6_err", err, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
